gth_word_aligner: RTL

Downstream of the GTH RX wrapper. Consumes the raw 32-bit parallel word stream in the RX word-clock domain and finds the bit offset of a fixed sync word. It then emits word-aligned data with start-of-frame marking, and tracks lock and lock loss. Frames are FRAME_LEN words long, with the sync word as word 0.

---
 rtl/gth_align_pkg.sv | 21 ++
 rtl/gth_sync_matcher.sv | 34 +++
 rtl/gth_word_aligner.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/gth_align_pkg.sv
// Shared types and helpers for the GTH RX word aligner: FSM states,
// window geometry and window extraction from the two-word concatenation.
package gth_align_pkg;

  localparam int WORD_W   = 32;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED
  } align_state_t;

  // Bits [k+31:k] of {current word, previous word}; k = 0 is the oldest bit.
  function automatic logic [WORD_W-1:0] window_at(input logic [2*WORD_W-1:0] concat,
                                                  input logic [OFFSET_W-1:0] k);
    return concat[{1'b0, k} +: WORD_W];
  endfunction

endpackage

// File: rtl/gth_sync_matcher.sv
// Combinational sync-word search across all 32 bit offsets of the window,
// with the lowest matching offset reported and a match flag for the selected offset.
module gth_sync_matcher
  import gth_align_pkg::*;
(
  input  logic [2*WORD_W-1:0] i_concat,
  input  logic [WORD_W-1:0]   i_pattern,
  input  logic [OFFSET_W-1:0] i_offset,
  output logic                o_hit,
  output logic [OFFSET_W-1:0] o_first_k,
  output logic                o_match_at
);

  logic [WORD_W-1:0] w_match;

  always_comb begin
    for (int k = 0; k < WORD_W; k++) begin
      w_match[k] = (window_at(i_concat, OFFSET_W'(k)) == i_pattern);
    end
  end

  assign o_hit      = |w_match;
  assign o_match_at = w_match[i_offset];

  // Scan downwards so the lowest matching offset is the last one written.
  always_comb begin
    // NOTE: a default before the loop keeps o_first_k fully assigned, so no latch is inferred.
    o_first_k = '0;
    for (int k = WORD_W - 1; k >= 0; k--) begin
      if (w_match[k]) o_first_k = OFFSET_W'(k);
    end
  end

endmodule

// File: rtl/gth_word_aligner.sv
// Word aligner for the GTH RX stream: finds the sync-word bit offset,
// verifies frame spacing, then emits aligned words with SOF and lock tracking.
module gth_word_aligner
  import gth_align_pkg::*;
#(
  parameter logic [WORD_W-1:0] SYNC_PATTERN = 32'hBC50_F7A3,
  parameter int                FRAME_LEN    = 8,
  parameter int                VERIFY_COUNT = 3,
  parameter int                MISS_LIMIT   = 4
) (
  input  logic                RX_WORDCLK_i,
  input  logic                RX_RESET_i,
  input  logic [WORD_W-1:0]   RAW_DATA_i,
  input  logic                RX_READY_i,
  input  logic                FORCE_RESYNC_i,
  output logic [WORD_W-1:0]   ALIGNED_DATA_o,
  output logic                ALIGNED_VALID_o,
  output logic                SOF_o,
  output logic                LOCKED_o,
  output logic [OFFSET_W-1:0] OFFSET_o,
  output logic [15:0]         LOCK_LOSS_CNT_o
);

  localparam logic [15:0] L_FRAME_LAST = 16'(FRAME_LEN - 1);
  localparam logic [15:0] L_VERIFY     = 16'(VERIFY_COUNT);
  localparam logic [15:0] L_MISS       = 16'(MISS_LIMIT);

  align_state_t        r_state;
  logic [WORD_W-1:0]   r_prev;
  logic [OFFSET_W-1:0] r_offset;
  logic [15:0]         r_hit_cnt;
  logic [15:0]         r_miss_cnt;
  logic [15:0]         r_frame_pos;
  logic [15:0]         r_loss_cnt;
  logic [WORD_W-1:0]   r_data;
  logic                r_valid;
  logic                r_sof;
  logic                r_locked;

  logic [2*WORD_W-1:0] w_concat;
  logic                w_hit;
  logic [OFFSET_W-1:0] w_first_k;
  logic                w_match_at;
  logic                w_pos_zero;
  logic [15:0]         w_pos_next;
  logic [15:0]         w_hit_next;
  logic [15:0]         w_miss_next;

  assign w_concat    = {RAW_DATA_i, r_prev};
  assign w_pos_zero  = (r_frame_pos == 16'd0);
  assign w_pos_next  = (r_frame_pos == L_FRAME_LAST) ? 16'd0 : r_frame_pos + 16'd1;
  assign w_hit_next  = r_hit_cnt + 16'd1;
  assign w_miss_next = r_miss_cnt + 16'd1;

  gth_sync_matcher u_matcher (
    .i_concat   (w_concat),
    .i_pattern  (SYNC_PATTERN),
    .i_offset   (r_offset),
    .o_hit      (w_hit),
    .o_first_k  (w_first_k),
    .o_match_at (w_match_at)
  );

  always_ff @(posedge RX_WORDCLK_i or posedge RX_RESET_i) begin
    if (RX_RESET_i) begin
      r_state     <= ST_IDLE;
      r_prev      <= '0;
      r_offset    <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_frame_pos <= '0;
      r_loss_cnt  <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_sof       <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here are overridden by later assignments in this block; last write wins.
      r_prev   <= RAW_DATA_i;
      r_data   <= window_at(w_concat, r_offset);
      r_valid  <= 1'b0;
      r_sof    <= 1'b0;
      r_locked <= 1'b0;

      if (!RX_READY_i || FORCE_RESYNC_i) begin
        r_state     <= RX_READY_i ? ST_SEARCH : ST_IDLE;
        r_hit_cnt   <= '0;
        r_miss_cnt  <= '0;
        r_frame_pos <= '0;
      end else begin
        unique case (r_state)
          ST_IDLE: r_state <= ST_SEARCH;

          ST_SEARCH: begin
            if (w_hit) begin
              r_offset    <= w_first_k;
              r_hit_cnt   <= 16'd1;
              r_frame_pos <= 16'd1;
              r_state     <= ST_VERIFY;
            end
          end

          ST_VERIFY: begin
            r_frame_pos <= w_pos_next;
            if (w_pos_zero) begin
              if (w_match_at) begin
                r_hit_cnt <= w_hit_next;
                if (w_hit_next == L_VERIFY) begin
                  r_state    <= ST_LOCKED;
                  r_miss_cnt <= '0;
                  r_valid    <= 1'b1;
                  r_sof      <= 1'b1;
                  r_locked   <= 1'b1;
                end
              end else begin
                r_state   <= ST_SEARCH;
                r_hit_cnt <= '0;
              end
            end
          end

          ST_LOCKED: begin
            r_frame_pos <= w_pos_next;
            r_valid     <= 1'b1;
            r_locked    <= 1'b1;
            r_sof       <= w_pos_zero;
            if (w_pos_zero && w_match_at) begin
              r_miss_cnt <= '0;
            end else if (w_pos_zero && (w_miss_next == L_MISS)) begin
              // Lock lost: this word goes out invalid and the loss is counted.
              r_state     <= ST_SEARCH;
              r_miss_cnt  <= '0;
              r_hit_cnt   <= '0;
              r_frame_pos <= '0;
              r_valid     <= 1'b0;
              r_sof       <= 1'b0;
              r_locked    <= 1'b0;
              if (r_loss_cnt != 16'hFFFF) r_loss_cnt <= r_loss_cnt + 16'd1;
            end else if (w_pos_zero) begin
              r_miss_cnt <= w_miss_next;
            end
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign ALIGNED_DATA_o  = r_data;
  assign ALIGNED_VALID_o = r_valid;
  assign SOF_o           = r_sof;
  assign LOCKED_o        = r_locked;
  assign OFFSET_o        = r_offset;
  assign LOCK_LOSS_CNT_o = r_loss_cnt;

endmodule
